// File: rtl/quantizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quantizer_pkg
//  Description : Shared types and decision thresholds for the float-to-level
//                quantizer that feeds the HDC level-hypervector LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
package quantizer_pkg;

    // Level index addressing the level-hypervector LUT
    typedef logic [3:0] level_t;

    // Decision thresholds as binary32 patterns (round-to-nearest)
    localparam logic [31:0] T1 = 32'h3E638E39;  // 2/9
    localparam logic [31:0] T2 = 32'h3EE38E39;  // 4/9
    localparam logic [31:0] T3 = 32'h3F2AAAAB;  // 2/3
    localparam logic [31:0] T4 = 32'h3F638E39;  // 8/9

    localparam int     NUM_LEVELS = 10;
    localparam level_t LEVEL_MID  = 4'd5;

endpackage : quantizer_pkg
`default_nettype wire

// File: rtl/quant_mag_bin.sv
`default_nettype none
// ============================================================================
//  Module      : quant_mag_bin
//  Description : Bins a 31-bit float magnitude against the four positive
//                thresholds. bin_o counts thresholds with mag >= T; eq_o
//                flags an exact threshold hit so the negative side can
//                move ties toward the higher level.
//  Revision    : 1.0 - initial release
// ============================================================================
module quant_mag_bin
    import quantizer_pkg::*;
(
    input  logic [30:0] mag_i,
    output logic [2:0]  bin_o,
    output logic [3:0]  eq_o
);

    // Magnitude-only thresholds: for non-negative binary32 patterns the
    // unsigned integer order equals the numeric order.
    localparam logic [30:0] T1_MAG = T1[30:0];
    localparam logic [30:0] T2_MAG = T2[30:0];
    localparam logic [30:0] T3_MAG = T3[30:0];
    localparam logic [30:0] T4_MAG = T4[30:0];

    logic [3:0] ge_w;

    // Threshold comparisons; ge_w is thermometer coded because T1<T2<T3<T4
    always_comb begin
        ge_w[0] = (mag_i >= T1_MAG);
        ge_w[1] = (mag_i >= T2_MAG);
        ge_w[2] = (mag_i >= T3_MAG);
        ge_w[3] = (mag_i >= T4_MAG);
        eq_o[0] = (mag_i == T1_MAG);
        eq_o[1] = (mag_i == T2_MAG);
        eq_o[2] = (mag_i == T3_MAG);
        eq_o[3] = (mag_i == T4_MAG);
    end

    // Thermometer-to-binary conversion of the bin index
    always_comb begin
        bin_o = 3'd0;
        if (ge_w[3])      bin_o = 3'd4;
        else if (ge_w[2]) bin_o = 3'd3;
        else if (ge_w[1]) bin_o = 3'd2;
        else if (ge_w[0]) bin_o = 3'd1;
    end

endmodule : quant_mag_bin
`default_nettype wire

// File: rtl/float_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : float_quantizer
//  Description : Maps a binary32 value in [-1,1] to a level index 0..9
//                (level k ~ -1 + 2k/9). Saturates out-of-range values, sends
//                NaN to mid-scale, registers the result with clock enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_quantizer
    import quantizer_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [31:0] input_value,
    output logic [3:0]  quantized_value_level
);

    logic        sign_w;
    logic [30:0] mag_w;
    logic        is_nan_w;
    logic        is_zero_w;
    logic        tie_w;
    logic [2:0]  bin_w;
    logic [3:0]  eq_w;
    level_t      level_d;
    level_t      level_q;

    assign sign_w    = input_value[31];
    assign mag_w     = input_value[30:0];
    assign is_nan_w  = (&input_value[30:23]) && (|input_value[22:0]);
    assign is_zero_w = (mag_w == 31'd0);
    assign tie_w     = |eq_w;

    quant_mag_bin u_mag_bin (
        .mag_i (mag_w),
        .bin_o (bin_w),
        .eq_o  (eq_w)
    );

    // Final level: positive side counts up from mid-scale; negative side counts
    // down from 4, but an exact threshold hit (x == -T) stays in the upper bin.
    always_comb begin
        level_d = LEVEL_MID;
        if (is_nan_w) begin
            level_d = LEVEL_MID;
        end else if (!sign_w || is_zero_w) begin
            level_d = LEVEL_MID + level_t'(bin_w);
        end else begin
            level_d = 4'd4 - level_t'(bin_w) + level_t'(tie_w);
        end
    end

    // Output register: async clear, loads only when enabled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            level_q <= 4'd0;
        end else if (en) begin
            level_q <= level_d;
        end
    end

    assign quantized_value_level = level_q;

endmodule : float_quantizer
`default_nettype wire

// File: tb/tb_float_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_quantizer
//  Description : Self-checking bench for float_quantizer. Expected levels come
//                from a real-valued model that decodes binary32 and counts the
//                thresholds the value reaches.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_quantizer;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [31:0] input_value;
    logic [3:0]  quantized_value_level;

    int errors = 0;
    int checks = 0;

    float_quantizer dut (
        .clk                   (clk),
        .nrst                  (nrst),
        .en                    (en),
        .input_value           (input_value),
        .quantized_value_level (quantized_value_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2^n as an exact real
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Decode a finite or infinite binary32 to a real (inf -> +-1e300)
    function automatic real fp_to_real(input logic [31:0] b);
        int  e;
        real m;
        real r;
        e = int'(b[30:23]);
        m = real'(b[22:0]);
        if (e == 255)    r = 1.0e300;
        else if (e == 0) r = m * pow2(-149);
        else             r = (8388608.0 + m) * pow2(e - 150);
        return b[31] ? -r : r;
    endfunction

    // Reference: NaN -> 5, otherwise count the nine thresholds x >= t
    function automatic int ref_level(input logic [31:0] v);
        logic [31:0] tp[4];
        real x;
        real t;
        int  lvl;
        tp[0] = 32'h3E638E39; tp[1] = 32'h3EE38E39;
        tp[2] = 32'h3F2AAAAB; tp[3] = 32'h3F638E39;
        if (v[30:23] == 8'hFF && v[22:0] != 23'd0) return 5;
        x   = fp_to_real(v);
        lvl = (x >= 0.0) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            t = fp_to_real(tp[k]);
            if (x >= t)  lvl++;
            if (x >= -t) lvl++;
        end
        return lvl;
    endfunction

    task automatic check(input string tag, input int expv);
        checks++;
        assert (quantized_value_level === 4'(expv))
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, quantized_value_level, expv);
        end
    endtask

    // Drive at the falling edge, then settle just after the next rising edge
    task automatic apply(input logic [31:0] v, input logic e);
        @(negedge clk);
        input_value = v;
        en          = e;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [31:0] v);
        apply(v, 1'b1);
        check(tag, ref_level(v));
    endtask

    initial begin
        logic [31:0] tp[4];
        logic [31:0] v;
        int          exp_q;
        logic        e;
        tp[0] = 32'h3E638E39; tp[1] = 32'h3EE38E39;
        tp[2] = 32'h3F2AAAAB; tp[3] = 32'h3F638E39;

        // Reset state, held across edges with en=1
        nrst = 1'b0; en = 1'b1; input_value = 32'h3F800000;
        #2;
        check("reset_async", 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 0);
        @(negedge clk);
        nrst = 1'b1;

        // Positive and negative sweeps (spot constants plus model)
        apply(32'h3F800000, 1'b1); check("p1.0", 9);
        apply(32'h3F333333, 1'b1); check("p0.7", 8);
        apply(32'h3F000000, 1'b1); check("p0.5", 7);
        apply(32'h3E99999A, 1'b1); check("p0.3", 6);
        apply(32'h3DCCCCCD, 1'b1); check("p0.1", 5);
        apply(32'hBDCCCCCD, 1'b1); check("n0.1", 4);
        apply(32'hBE99999A, 1'b1); check("n0.3", 3);
        apply(32'hBF000000, 1'b1); check("n0.5", 2);
        apply(32'hBF333333, 1'b1); check("n0.7", 1);
        apply(32'hBF800000, 1'b1); check("n1.0", 0);

        // Async reset mid-operation
        apply(32'hBF333333, 1'b1); check("pre_rst", 1);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("mid_rst", 0);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", 1);

        // Enable hold
        apply(32'hBF800000, 1'b0); check("hold1", 1);
        apply(32'hBF800000, 1'b0); check("hold2", 1);
        apply(32'hBF800000, 1'b1); check("hold_rel", 0);

        // Boundaries and special encodings
        apply(32'h3E638E39, 1'b1); check("pT1", 6);
        apply(32'hBE638E39, 1'b1); check("nT1", 4);
        apply(32'h3F638E39, 1'b1); check("pT4", 9);
        apply(32'hBF638E39, 1'b1); check("nT4", 1);
        apply(32'h00000000, 1'b1); check("pzero", 5);
        apply(32'h80000000, 1'b1); check("nzero", 5);
        apply(32'h40000000, 1'b1); check("p2.0", 9);
        apply(32'h7F800000, 1'b1); check("pinf", 9);
        apply(32'hFF800000, 1'b1); check("ninf", 0);
        apply(32'h7FC00000, 1'b1); check("nan", 5);
        apply(32'hFFC00001, 1'b1); check("nnan", 5);
        apply(32'h00000001, 1'b1); check("pdenorm", 5);
        apply(32'h80000001, 1'b1); check("ndenorm", 4);
        apply(32'hBEE38E39, 1'b1); check("nT2", 3);
        apply(32'h3F2AAAAB, 1'b1); check("pT3", 8);
        apply(32'hBF2AAAAB, 1'b1); check("nT3", 2);

        // Model-checked directed steps on all thresholds +/- one ulp
        for (int k = 0; k < 4; k++) begin
            step("thr_lo_p", tp[k] - 32'd1);
            step("thr_hi_p", tp[k] + 32'd1);
            step("thr_lo_n", {1'b1, tp[k][30:0] - 31'd1});
            step("thr_hi_n", {1'b1, tp[k][30:0] + 31'd1});
        end

        // Randomized: mixed encodings, with random enable tracked by the model
        exp_q = ref_level(32'hBF2AAAAB);
        apply(32'hBF2AAAAB, 1'b1);
        check("rnd_seed", exp_q);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0: v = $urandom;
                1: v = {1'($urandom), 8'($urandom_range(118, 128)), 23'($urandom)};
                default: begin
                    v = tp[$urandom_range(0, 3)] + 32'($urandom_range(0, 6)) - 32'd3;
                    v[31] = 1'($urandom);
                end
            endcase
            e = ($urandom_range(0, 4) != 0);
            if (e) exp_q = ref_level(v);
            apply(v, e);
            check("rnd", exp_q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_float_quantizer
`default_nettype wire
